// File: rtl/mux32_rr_arbiter_if.sv
// rtl/mux32_rr_arbiter_if.sv - request/grant/stream bundle for mux32_rr_arbiter
//
// Purpose: groups the 32 requester inputs, the granted-slot outputs and the
//          downstream valid/ready handshake into a single port.
// Signals:
//   req        [31:0]     per-slot request
//   din        [32*N-1:0] packed slot data, slot i = din[i*N +: N]
//   grant      [31:0]     one-hot grant (registered)
//   sel        [4:0]      mux select, index of granted slot (registered)
//   out_valid             out_data valid (registered)
//   out_data   [N-1:0]    selected slot data (combinational)
//   out_ready             downstream accepts out_data
//   xfer_count [15:0]     completed transfers, wrapping
// Modports: master = arbiter side, slave = requesters/consumer side.

interface mux32_rr_arbiter_if #(
   parameter int N = 4
);
   logic [31:0]     req;
   logic [32*N-1:0] din;
   logic [31:0]     grant;
   logic [4:0]      sel;
   logic            out_valid;
   logic [N-1:0]    out_data;
   logic            out_ready;
   logic [15:0]     xfer_count;

   modport master (
      input  req, din, out_ready,
      output grant, sel, out_valid, out_data, xfer_count
   );

   modport slave (
      output req, din, out_ready,
      input  grant, sel, out_valid, out_data, xfer_count
   );
endinterface

// File: rtl/mux32_rr_arbiter.sv
// rtl/mux32_rr_arbiter.sv - round-robin arbiter sharing one mux32 among 32 slots
//
// Purpose: picks one requesting slot in round-robin order starting after the
//          last completed slot, drives sel/grant and presents that slot's data
//          with a valid/ready handshake. Counts completed transfers.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous active-high reset
//   io_bus  mux32_rr_arbiter_if.master (req, din, out_ready in;
//           grant, sel, out_valid, out_data, xfer_count out)

// mux32 - 32:1 selector of N-bit slots from a packed vector.
module mux32 #(
   parameter int N = 4
) (
   input  logic [32*N-1:0] i_din,
   input  logic [4:0]      i_sel,
   output logic [N-1:0]    o_data
);
   assign o_data = i_din[i_sel*N +: N];
endmodule

module mux32_rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   mux32_rr_arbiter_if.master   io_bus
);
   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t       r_state,  w_state_nx;
   logic [4:0]   r_sel,    w_sel_nx;
   logic [31:0]  r_grant,  w_grant_nx;
   logic         r_valid,  w_valid_nx;
   logic [4:0]   r_ptr,    w_ptr_nx;
   logic [15:0]  r_xfer,   w_xfer_nx;
   logic [4:0]   w_winner;
   logic         w_found;
   logic [N-1:0] w_mux_data;

   mux32 #(.N(N)) u_mux (
      .i_din  (io_bus.din),
      .i_sel  (r_sel),
      .o_data (w_mux_data)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_sel   <= 5'd0;
         r_grant <= 32'd0;
         r_valid <= 1'b0;
         r_ptr   <= 5'd31;
         r_xfer  <= 16'd0;
      end else begin
         r_state <= w_state_nx;
         r_sel   <= w_sel_nx;
         r_grant <= w_grant_nx;
         r_valid <= w_valid_nx;
         r_ptr   <= w_ptr_nx;
         r_xfer  <= w_xfer_nx;
      end
   end

   // Next-state logic
   always_comb begin
      logic [4:0] idx;
      idx        = 5'd0;
      w_found    = 1'b0;
      w_winner   = 5'd0;
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_grant_nx = r_grant;
      w_valid_nx = r_valid;
      w_ptr_nx   = r_ptr;
      w_xfer_nx  = r_xfer;

      // Scan from farthest to nearest offset after ptr so the nearest
      // requester is the last one written and therefore wins.
      for (int i = 31; i >= 0; i--) begin
         idx = r_ptr + 5'd1 + 5'(i);
         if (io_bus.req[idx]) begin
            w_found  = 1'b1;
            w_winner = idx;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nx = ST_GRANT;
               w_sel_nx   = w_winner;
               w_grant_nx = 32'd1 << w_winner;
               w_valid_nx = 1'b1;
            end
         end
         ST_GRANT: begin
            if (io_bus.out_ready) begin
               // Ready wins even if the requester dropped req this cycle.
               w_state_nx = ST_IDLE;
               w_grant_nx = 32'd0;
               w_valid_nx = 1'b0;
               w_ptr_nx   = r_sel;
               w_xfer_nx  = r_xfer + 16'd1;
            end else if (!io_bus.req[r_sel]) begin
               // Abort: ptr untouched so the slot keeps its priority position.
               w_state_nx = ST_IDLE;
               w_grant_nx = 32'd0;
               w_valid_nx = 1'b0;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      io_bus.grant      = r_grant;
      io_bus.sel        = r_sel;
      io_bus.out_valid  = r_valid;
      io_bus.out_data   = w_mux_data;
      io_bus.xfer_count = r_xfer;
   end
endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// tb/tb_mux32_rr_arbiter.sv - table-driven scoreboard bench for mux32_rr_arbiter

module tb_mux32_rr_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux32_rr_arbiter_if #(.N(4)) bus ();

   mux32_rr_arbiter #(.N(4)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] req;
      logic        rdy;
      logic [31:0] e_grant;
      logic [4:0]  e_sel;
      logic        e_valid;
      logic [15:0] e_xfer;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Expected outputs are those seen after the edge that samples the inputs.
   function automatic void add(string nm, logic r, logic [31:0] rq, logic rd,
                               logic v, logic [4:0] s, logic [15:0] x);
      vec_t e;
      e.name    = nm;
      e.rst     = r;
      e.req     = rq;
      e.rdy     = rd;
      e.e_valid = v;
      e.e_sel   = s;
      e.e_grant = v ? (32'd1 << s) : 32'd0;
      e.e_xfer  = x;
      tbl.push_back(e);
   endfunction

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic check_vec(vec_t e);
      logic [3:0] exp_data;
      exp_data = ~e.e_sel[3:0];
      cmp({e.name, ".grant"}, bus.grant, e.e_grant);
      cmp({e.name, ".sel"}, {27'd0, bus.sel}, {27'd0, e.e_sel});
      cmp({e.name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, e.e_valid});
      cmp({e.name, ".xfer"}, {16'd0, bus.xfer_count}, {16'd0, e.e_xfer});
      if (e.e_valid)
         cmp({e.name, ".data"}, {28'd0, bus.out_data}, {28'd0, exp_data});
   endtask

   initial begin
      logic [31:0] w2;
      logic [31:0] w78;

      // Slot i carries ~i[3:0], so slot 5 holds 4'hA.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] iv;
         iv = 5'(i);
         bus.din[i*4 +: 4] = ~iv[3:0];
      end
      rst           = 1'b1;
      bus.req       = 32'd0;
      bus.out_ready = 1'b0;

      // Reset and idle
      add("rst", 1, 32'd0, 0, 0, 0, 0);
      add("rst", 1, 32'd0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add("idle", 0, 32'd0, 0, 0, 0, 0);

      // Single slot 5, held three cycles then accepted
      add("t2_req",  0, 32'h20, 0, 1, 5, 0);
      add("t2_hold", 0, 32'h20, 0, 1, 5, 0);
      add("t2_hold", 0, 32'h20, 0, 1, 5, 0);
      add("t2_done", 0, 32'h20, 1, 0, 5, 1);
      add("t2_idle", 0, 32'd0,  0, 0, 5, 1);

      // All requesting with ready high: two laps, slot order 0..31,0..31
      add("t3_rst", 1, 32'hFFFF_FFFF, 1, 0, 0, 0);
      for (int k = 0; k < 64; k++) begin
         add("t3_grant", 0, 32'hFFFF_FFFF, 1, 1, 5'(k), 16'(k));
         add("t3_done",  0, 32'hFFFF_FFFF, 1, 0, 5'(k), 16'(k + 1));
      end

      // Wrap: last completed slot is 31, so slot 0 precedes slot 31
      w2 = 32'h8000_0001;
      add("t4_g0",  0, w2, 1, 1, 0,  64);
      add("t4_d0",  0, w2, 1, 0, 0,  65);
      add("t4_g31", 0, w2, 1, 1, 31, 65);
      add("t4_d31", 0, w2, 1, 0, 31, 66);

      // Abort of slot 7 keeps its priority; then ready wins over dropped req
      w78 = 32'h180;
      add("t5_g7",      0, 32'h80,  0, 1, 7, 66);
      add("t5_abort",   0, 32'd0,   0, 0, 7, 66);
      add("t5_regrant", 0, w78,     0, 1, 7, 66);
      add("t5_d7",      0, w78,     1, 0, 7, 67);
      add("t5_g8",      0, 32'h100, 0, 1, 8, 67);
      add("t5_rdywin",  0, 32'd0,   1, 0, 8, 68);

      // Reset in the middle of a grant
      add("t6_g12",  0, 32'h1000,      0, 1, 12, 68);
      add("t6_hold", 0, 32'h1000,      0, 1, 12, 68);
      add("t6_rst",  1, 32'h1000,      0, 0, 0,  0);
      add("t6_g0",   0, 32'hFFFF_FFFF, 0, 1, 0,  0);
      add("t6_d0",   0, 32'hFFFF_FFFF, 1, 0, 0,  1);
      add("end_idle", 0, 32'd0,        0, 0, 0,  1);

      foreach (tbl[i]) begin
         @(negedge clk);
         if (sb.size() > 0) check_vec(sb.pop_front());
         rst           = tbl[i].rst;
         bus.req       = tbl[i].req;
         bus.out_ready = tbl[i].rdy;
         sb.push_back(tbl[i]);
      end
      @(negedge clk);
      while (sb.size() > 0) check_vec(sb.pop_front());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
